lcd_ctrl_param: RTL and testbench



---
 rtl/lcd_pkg.sv | 32 +++
 rtl/lcd_ctrl_param_if.sv | 33 +++
 rtl/lcd_window_alu.sv | 86 ++++++++
 rtl/lcd_ctrl_param.sv | 169 ++++++++++++++++
 tb/tb_lcd_ctrl_param.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the parametrised LCD image controller.
// Contents: command codes, controller state encoding, and the helper
// that places the reset window origin at the image centre.
package lcd_pkg;

    localparam logic [3:0] CMD_WRITE       = 4'h0;
    localparam logic [3:0] CMD_SHIFT_UP    = 4'h1;
    localparam logic [3:0] CMD_SHIFT_DOWN  = 4'h2;
    localparam logic [3:0] CMD_SHIFT_LEFT  = 4'h3;
    localparam logic [3:0] CMD_SHIFT_RIGHT = 4'h4;
    localparam logic [3:0] CMD_MAX         = 4'h5;
    localparam logic [3:0] CMD_MIN         = 4'h6;
    localparam logic [3:0] CMD_AVG         = 4'h7;
    localparam logic [3:0] CMD_ROT_CCW     = 4'h8;
    localparam logic [3:0] CMD_ROT_CW      = 4'h9;
    localparam logic [3:0] CMD_MIRROR_X    = 4'hA;
    localparam logic [3:0] CMD_MIRROR_Y    = 4'hB;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_LOAD,
        ST_IDLE,
        ST_EXEC,
        ST_WRITE
    } state_t;

    // Window origin coordinate for one image dimension after reset.
    function automatic int unsigned reset_origin(input int unsigned dim);
        return dim / 2 - 1;
    endfunction

endpackage

// File: rtl/lcd_ctrl_param_if.sv
// Host/memory bus of the LCD controller.
// slave  : controller side (cmd, cmd_valid, IROM_Q in; IROM_EN, IROM_A,
//          IRB_RW, IRB_A, IRB_D, busy, done out)
// master : host/memory side, directions mirrored.
interface lcd_ctrl_param_if #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 8
);
    localparam int ADDR_W = $clog2(IMG_W * IMG_H);

    logic [3:0]        cmd;
    logic              cmd_valid;
    logic [DATA_W-1:0] IROM_Q;
    logic              IROM_EN;
    logic [ADDR_W-1:0] IROM_A;
    logic              IRB_RW;
    logic [ADDR_W-1:0] IRB_A;
    logic [DATA_W-1:0] IRB_D;
    logic              busy;
    logic              done;

    modport slave (
        input  cmd, cmd_valid, IROM_Q,
        output IROM_EN, IROM_A, IRB_RW, IRB_A, IRB_D, busy, done
    );

    modport master (
        output cmd, cmd_valid, IROM_Q,
        input  IROM_EN, IROM_A, IRB_RW, IRB_A, IRB_D, busy, done
    );

endinterface

// File: rtl/lcd_window_alu.sv
// Combinational 2x2 window operator.
// i_cmd              : command code
// i_tl/i_tr/i_bl/i_br: current window pixels
// o_tl/o_tr/o_bl/o_br: new window pixels
// o_we               : per-pixel write enable {br, bl, tr, tl}
module lcd_window_alu
    import lcd_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        i_cmd,
    input  logic [DATA_W-1:0] i_tl,
    input  logic [DATA_W-1:0] i_tr,
    input  logic [DATA_W-1:0] i_bl,
    input  logic [DATA_W-1:0] i_br,
    output logic [DATA_W-1:0] o_tl,
    output logic [DATA_W-1:0] o_tr,
    output logic [DATA_W-1:0] o_bl,
    output logic [DATA_W-1:0] o_br,
    output logic [3:0]        o_we
);
    logic [DATA_W-1:0] w_max_t, w_max_b, w_max;
    logic [DATA_W-1:0] w_min_t, w_min_b, w_min;
    logic [DATA_W+1:0] w_sum;

    assign w_max_t = (i_tl > i_tr) ? i_tl : i_tr;
    assign w_max_b = (i_bl > i_br) ? i_bl : i_br;
    assign w_max   = (w_max_t > w_max_b) ? w_max_t : w_max_b;
    assign w_min_t = (i_tl < i_tr) ? i_tl : i_tr;
    assign w_min_b = (i_bl < i_br) ? i_bl : i_br;
    assign w_min   = (w_min_t < w_min_b) ? w_min_t : w_min_b;
    // Two guard bits make the four-way sum exact; dropping two LSBs is floor(sum/4).
    assign w_sum   = {2'b00, i_tl} + {2'b00, i_tr} + {2'b00, i_bl} + {2'b00, i_br};

    always_comb begin
        o_tl = i_tl;
        o_tr = i_tr;
        o_bl = i_bl;
        o_br = i_br;
        o_we = 4'h0;
        case (i_cmd)
            CMD_MAX: begin
                {o_tl, o_tr, o_bl, o_br} = {4{w_max}};
                o_we = 4'hF;
            end
            CMD_MIN: begin
                {o_tl, o_tr, o_bl, o_br} = {4{w_min}};
                o_we = 4'hF;
            end
            CMD_AVG: begin
                {o_tl, o_tr, o_bl, o_br} = {4{w_sum[DATA_W+1:2]}};
                o_we = 4'hF;
            end
            CMD_ROT_CCW: begin
                o_tl = i_tr;
                o_tr = i_br;
                o_br = i_bl;
                o_bl = i_tl;
                o_we = 4'hF;
            end
            CMD_ROT_CW: begin
                o_tl = i_bl;
                o_tr = i_tl;
                o_br = i_tr;
                o_bl = i_br;
                o_we = 4'hF;
            end
            CMD_MIRROR_X: begin
                o_tl = i_bl;
                o_bl = i_tl;
                o_tr = i_br;
                o_br = i_tr;
                o_we = 4'hF;
            end
            CMD_MIRROR_Y: begin
                o_tl = i_tr;
                o_tr = i_tl;
                o_bl = i_br;
                o_br = i_bl;
                o_we = 4'hF;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD image controller: loads an IMG_W x IMG_H image from
// IROM, runs 2x2 window commands from the host, streams the image to IRB.
// clk   : clock, rising edge
// reset : asynchronous, active-high
// bus   : lcd_ctrl_param_if.slave (command handshake, IROM read, IRB write)
//
// state    | meaning
// ST_INIT  | one cycle after reset, arms the IROM read
// ST_LOAD  | IROM addresses 0..N-1 issued, pixels captured one cycle later
// ST_IDLE  | busy=0, waiting for a valid command
// ST_EXEC  | window/origin update commits at the end of this cycle
// ST_WRITE | buffer streamed to IRB, done pulses as IDLE is re-entered
module lcd_ctrl_param
    import lcd_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    lcd_ctrl_param_if.slave  bus
);
    localparam int N      = IMG_W * IMG_H;
    localparam int X_W    = $clog2(IMG_W);
    localparam int Y_W    = $clog2(IMG_H);
    localparam int ADDR_W = X_W + Y_W;
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [X_W-1:0]    X_RST  = X_W'(reset_origin(IMG_W));
    localparam logic [Y_W-1:0]    Y_RST  = Y_W'(reset_origin(IMG_H));
    localparam logic [X_W-1:0]    X_MAX  = X_W'(IMG_W - 2);
    localparam logic [Y_W-1:0]    Y_MAX  = Y_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(N - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [3:0]        r_cmd;
    logic              r_busy, r_done, r_irom_en, r_irb_rw;
    logic [ADDR_W-1:0] r_irom_a, r_irb_a;
    logic [DATA_W-1:0] r_irb_d;
    logic [DATA_W-1:0] r_buf [N];

    logic [X_W-1:0]    w_x1;
    logic [Y_W-1:0]    w_y1;
    logic [ADDR_W-1:0] w_a_tl, w_a_tr, w_a_bl, w_a_br, w_load_a, w_irb_nxt;
    logic [DATA_W-1:0] w_n_tl, w_n_tr, w_n_bl, w_n_br;
    logic [3:0]        w_we;

    // Power-of-two dimensions make y*IMG_W + x a plain concatenation.
    assign w_x1      = r_x + X_W'(1);
    assign w_y1      = r_y + Y_W'(1);
    assign w_a_tl    = {r_y,  r_x};
    assign w_a_tr    = {r_y,  w_x1};
    assign w_a_bl    = {w_y1, r_x};
    assign w_a_br    = {w_y1, w_x1};
    assign w_load_a  = ADDR_W'(r_cnt - CNT_W'(1));
    assign w_irb_nxt = r_irb_a + ADDR_W'(1);

    lcd_window_alu #(.DATA_W(DATA_W)) u_alu (
        .i_cmd (r_cmd),
        .i_tl  (r_buf[w_a_tl]),
        .i_tr  (r_buf[w_a_tr]),
        .i_bl  (r_buf[w_a_bl]),
        .i_br  (r_buf[w_a_br]),
        .o_tl  (w_n_tl),
        .o_tr  (w_n_tr),
        .o_bl  (w_n_bl),
        .o_br  (w_n_br),
        .o_we  (w_we)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_INIT;
            r_cnt     <= '0;
            r_x       <= X_RST;
            r_y       <= Y_RST;
            r_cmd     <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_irom_en <= 1'b1;
            r_irom_a  <= '0;
            r_irb_rw  <= 1'b1;
            r_irb_a   <= '0;
            r_irb_d   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_state   <= ST_LOAD;
                    r_cnt     <= '0;
                    r_irom_en <= 1'b0;
                    r_irom_a  <= '0;
                end
                ST_LOAD: begin
                    // r_cnt runs 0..N: the extra cycle captures the last pixel.
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_irom_a == A_LAST) r_irom_en <= 1'b1;
                    else                    r_irom_a  <= r_irom_a + ADDR_W'(1);
                    if (r_cnt == CNT_W'(N)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_busy <= 1'b1;
                        r_cmd  <= bus.cmd;
                        if (bus.cmd == CMD_WRITE) begin
                            r_state  <= ST_WRITE;
                            r_irb_rw <= 1'b0;
                            r_irb_a  <= '0;
                            r_irb_d  <= r_buf[0];
                        end else begin
                            r_state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    case (r_cmd)
                        CMD_SHIFT_UP:    if (r_y != '0)   r_y <= r_y - Y_W'(1);
                        CMD_SHIFT_DOWN:  if (r_y != Y_MAX) r_y <= w_y1;
                        CMD_SHIFT_LEFT:  if (r_x != '0)   r_x <= r_x - X_W'(1);
                        CMD_SHIFT_RIGHT: if (r_x != X_MAX) r_x <= w_x1;
                        default: ;
                    endcase
                end
                ST_WRITE: begin
                    if (r_irb_a == A_LAST) begin
                        r_irb_rw <= 1'b1;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_irb_a <= w_irb_nxt;
                        r_irb_d <= r_buf[w_irb_nxt];
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // Image buffer has no reset; reset forces ST_INIT so no write can occur.
    always_ff @(posedge clk) begin
        if (r_state == ST_LOAD && r_cnt != '0)
            r_buf[w_load_a] <= bus.IROM_Q;
        if (r_state == ST_EXEC) begin
            if (w_we[0]) r_buf[w_a_tl] <= w_n_tl;
            if (w_we[1]) r_buf[w_a_tr] <= w_n_tr;
            if (w_we[2]) r_buf[w_a_bl] <= w_n_bl;
            if (w_we[3]) r_buf[w_a_br] <= w_n_br;
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.IROM_EN = r_irom_en;
    assign bus.IROM_A  = r_irom_a;
    assign bus.IRB_RW  = r_irb_rw;
    assign bus.IRB_A   = r_irb_a;
    assign bus.IRB_D   = r_irb_d;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param: an 8x8 instance (a) and a 16x4 instance (b),
// each paired with an IROM model and an image/origin reference model.
module tb_lcd_ctrl_param;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    lcd_ctrl_param_if #(.IMG_W(8),  .IMG_H(8), .DATA_W(8)) bus_a ();
    lcd_ctrl_param_if #(.IMG_W(16), .IMG_H(4), .DATA_W(8)) bus_b ();

    lcd_ctrl_param #(.IMG_W(8),  .IMG_H(8), .DATA_W(8)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
    lcd_ctrl_param #(.IMG_W(16), .IMG_H(4), .DATA_W(8)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

    logic [7:0] rom   [2][64];
    logic [7:0] m_img [2][64];
    int         m_x [2];
    int         m_y [2];
    int         m_w [2] = '{8, 16};
    int         m_h [2] = '{8, 4};
    int         n_chk  = 0;
    int         n_fail = 0;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       irom_en;
        logic       irb_rw;
        logic [5:0] irom_a;
        logic [5:0] irb_a;
        logic [7:0] irb_d;
    } obs_t;

    // IROM: data for the address presented with IROM_EN=0 appears next cycle.
    always @(posedge clk) begin
        if (!bus_a.IROM_EN) bus_a.IROM_Q <= rom[0][bus_a.IROM_A];
        if (!bus_b.IROM_EN) bus_b.IROM_Q <= rom[1][bus_b.IROM_A];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        n_chk++;
        assert (obs_v === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
        end
    endtask

    function automatic obs_t obs(input int s);
        obs_t o;
        if (s == 0) begin
            o.busy = bus_a.busy;   o.done = bus_a.done;
            o.irom_en = bus_a.IROM_EN; o.irb_rw = bus_a.IRB_RW;
            o.irom_a = bus_a.IROM_A; o.irb_a = bus_a.IRB_A; o.irb_d = bus_a.IRB_D;
        end else begin
            o.busy = bus_b.busy;   o.done = bus_b.done;
            o.irom_en = bus_b.IROM_EN; o.irb_rw = bus_b.IRB_RW;
            o.irom_a = bus_b.IROM_A; o.irb_a = bus_b.IRB_A; o.irb_d = bus_b.IRB_D;
        end
        return o;
    endfunction

    task automatic set_in(input int s, input logic [3:0] c, input logic v);
        if (s == 0) begin bus_a.cmd = c; bus_a.cmd_valid = v; end
        else        begin bus_b.cmd = c; bus_b.cmd_valid = v; end
    endtask

    task automatic set_rst(input int s, input logic v);
        if (s == 0) rst_a = v;
        else        rst_b = v;
    endtask

    task automatic chk_reset(input int s);
        obs_t o;
        o = obs(s);
        chk("rst_busy", o.busy, 1);
        chk("rst_done", o.done, 0);
        chk("rst_irom_en", o.irom_en, 1);
        chk("rst_irb_rw", o.irb_rw, 1);
        chk("rst_irom_a", o.irom_a, 0);
        chk("rst_irb_a", o.irb_a, 0);
        chk("rst_irb_d", o.irb_d, 0);
    endtask

    // Called at a negedge with reset asserted: release and follow the full load.
    task automatic release_and_load(input int s);
        obs_t o;
        set_rst(s, 1'b0);
        for (int i = 0; i < 64; i++) m_img[s][i] = rom[s][i];
        m_x[s] = m_w[s] / 2 - 1;
        m_y[s] = m_h[s] / 2 - 1;
        @(negedge clk);
        for (int j = 0; j < 64; j++) begin
            o = obs(s);
            chk("ld_en", o.irom_en, 0);
            chk($sformatf("ld_a%0d", j), o.irom_a, j);
            chk("ld_busy", o.busy, 1);
            @(negedge clk);
        end
        o = obs(s);
        chk("ld_end_en", o.irom_en, 1);
        chk("ld_end_busy", o.busy, 1);
        @(negedge clk);
        o = obs(s);
        chk("ld_idle_busy", o.busy, 0);
    endtask

    task automatic do_write(input int s);
        obs_t o;
        set_in(s, 4'h0, 1'b1);
        @(negedge clk);
        for (int k = 0; k < 64; k++) begin
            o = obs(s);
            if (k == 0) set_in(s, 4'($urandom), 1'b0);
            chk("wr_rw", o.irb_rw, 0);
            chk("wr_busy", o.busy, 1);
            chk($sformatf("wr_a%0d", k), o.irb_a, k);
            chk($sformatf("wr_d%0d", k), o.irb_d, m_img[s][k]);
            @(negedge clk);
        end
        o = obs(s);
        chk("wr_end_rw", o.irb_rw, 1);
        chk("wr_done", o.done, 1);
        @(negedge clk);
        o = obs(s);
        chk("wr_done_fall", o.done, 0);
        chk("wr_idle_busy", o.busy, 0);
    endtask

    task automatic model_apply(input int s, input logic [3:0] c);
        int w, h, i0, mx, mn, sum;
        int idx [4];
        logic [7:0] p [4];
        logic [7:0] q [4];
        w = m_w[s]; h = m_h[s];
        i0 = m_y[s] * w + m_x[s];
        idx[0] = i0; idx[1] = i0 + 1; idx[2] = i0 + w; idx[3] = i0 + w + 1;
        mx = 0; mn = 255; sum = 0;
        for (int k = 0; k < 4; k++) begin
            p[k] = m_img[s][idx[k]];
            q[k] = p[k];
            if (int'(p[k]) > mx) mx = p[k];
            if (int'(p[k]) < mn) mn = p[k];
            sum += p[k];
        end
        case (c)
            4'h1: if (m_y[s] > 0)     m_y[s]--;
            4'h2: if (m_y[s] < h - 2) m_y[s]++;
            4'h3: if (m_x[s] > 0)     m_x[s]--;
            4'h4: if (m_x[s] < w - 2) m_x[s]++;
            4'h5: for (int k = 0; k < 4; k++) q[k] = 8'(mx);
            4'h6: for (int k = 0; k < 4; k++) q[k] = 8'(mn);
            4'h7: for (int k = 0; k < 4; k++) q[k] = 8'(sum / 4);
            4'h8: begin q[0] = p[1]; q[1] = p[3]; q[3] = p[2]; q[2] = p[0]; end
            4'h9: begin q[0] = p[2]; q[1] = p[0]; q[3] = p[1]; q[2] = p[3]; end
            4'hA: begin q[0] = p[2]; q[2] = p[0]; q[1] = p[3]; q[3] = p[1]; end
            4'hB: begin q[0] = p[1]; q[1] = p[0]; q[2] = p[3]; q[3] = p[2]; end
            default: ;
        endcase
        for (int k = 0; k < 4; k++) m_img[s][idx[k]] = q[k];
    endtask

    // poke keeps cmd_valid high through EXEC with another command; it must be dropped.
    task automatic do_cmd(input int s, input logic [3:0] c, input bit poke);
        obs_t o;
        set_in(s, c, 1'b1);
        @(negedge clk);
        o = obs(s);
        chk("exec_busy", o.busy, 1);
        if (poke) set_in(s, 4'($urandom_range(1, 4)), 1'b1);
        else      set_in(s, 4'($urandom), 1'b0);
        @(negedge clk);
        o = obs(s);
        chk("exec_idle_busy", o.busy, 0);
        chk("exec_done", o.done, 0);
        set_in(s, 4'h0, 1'b0);
        model_apply(s, c);
    endtask

    task automatic reset_in_load(input int s);
        obs_t o;
        int found;
        set_rst(s, 1'b1);
        @(negedge clk);
        set_rst(s, 1'b0);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            o = obs(s);
            if (!o.irom_en && o.irom_a == 6'd20) found = 1;
        end
        chk("wait_load_a20", found, 1);
        set_rst(s, 1'b1);
        #1;
        chk_reset(s);
        @(negedge clk);
        release_and_load(s);
    endtask

    task automatic random_cmds(input int s, input int n);
        for (int i = 0; i < n; i++)
            do_cmd(s, 4'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0));
    endtask

    initial begin
        obs_t o;
        set_in(0, 4'h0, 1'b0);
        set_in(1, 4'h0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            rom[0][i] = 8'(i);
            rom[1][i] = 8'($urandom);
        end
        repeat (3) @(negedge clk);
        chk_reset(0);
        chk_reset(1);

        release_and_load(0);
        do_write(0);

        do_cmd(0, 4'h9, 0);
        do_write(0);
        do_cmd(0, 4'h8, 0);
        do_write(0);
        do_cmd(0, 4'h7, 0);
        do_write(0);

        for (int i = 0; i < 5; i++) do_cmd(0, 4'h1, 0);
        for (int i = 0; i < 5; i++) do_cmd(0, 4'h3, 0);
        do_cmd(0, 4'h5, 0);
        do_cmd(0, 4'h1, 0);
        do_cmd(0, 4'h3, 0);
        do_cmd(0, 4'hC, 0);
        do_write(0);

        for (int i = 0; i < 10; i++) do_cmd(0, 4'h2, 0);
        for (int i = 0; i < 10; i++) do_cmd(0, 4'h4, 0);
        do_cmd(0, 4'h6, 1);
        do_cmd(0, 4'hA, 0);
        do_write(0);

        random_cmds(0, 40);
        do_write(0);

        set_rst(0, 1'b1);
        for (int i = 0; i < 64; i++) rom[0][i] = 8'($urandom);
        reset_in_load(0);
        random_cmds(0, 25);
        do_write(0);

        // Reset during an IRB stream truncates it and forces a reload.
        set_in(0, 4'h0, 1'b1);
        @(negedge clk);
        set_in(0, 4'h0, 1'b0);
        repeat (10) @(negedge clk);
        o = obs(0);
        chk("wr_mid_rw", o.irb_rw, 0);
        set_rst(0, 1'b1);
        #1;
        chk_reset(0);
        @(negedge clk);
        release_and_load(0);
        do_write(0);

        release_and_load(1);
        do_cmd(1, 4'h7, 0);
        do_write(1);
        random_cmds(1, 40);
        do_write(1);
        reset_in_load(1);
        do_cmd(1, 4'hB, 0);
        do_write(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
